// File: rtl/datapath_pkg.sv
// Shared datapath constants and types for the ELEC374 register slice.
// The register width and its clear value are taken from here by default.
package datapath_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  localparam word_t REG_RESET_VALUE = 32'h0;

endpackage : datapath_pkg

// File: rtl/reg_bit_cell.sv
// One storage bit: a D flip-flop with an asynchronous active-low clear to RST_BIT
// and a 2:1 enable mux that recirculates q when en is low.
module reg_bit_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  // NOTE: sequential state is written only with non-blocking (<=) assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= RST_BIT;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : reg_bit_cell

// File: rtl/register_32.sv
// Loadable datapath register built from WIDTH bit cells with async active-low clear.
// Define REGISTER_32_ZERO_GATE_EN to add the BAout read-as-zero gate on q.
module register_32
  import datapath_pkg::*;
#(
  parameter int          WIDTH       = DATA_W,
  parameter logic [63:0] RESET_VALUE = 64'(REG_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             R1in,
`ifdef REGISTER_32_ZERO_GATE_EN
  input  logic             BAout,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stored;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg_bit_cell #(
      .RST_BIT (RESET_VALUE[i])
    ) u_cell (
      .clk (clk),
      .clr (clr),
      .en  (R1in),
      .d   (d[i]),
      .q   (stored[i])
    );
  end

`ifdef REGISTER_32_ZERO_GATE_EN
  // The gate only masks the read path; the cells keep loading while BAout is high.
  assign q = BAout ? '0 : stored;
`else
  assign q = stored;
`endif

endmodule : register_32

// File: tb/tb_register_32.sv
// Self-checking bench for register_32: table-driven load/hold/clear vectors fed
// through an expected-value scoreboard, plus hand-written async clear sequences.
module tb_register_32;
  import datapath_pkg::*;

  logic  clk;
  logic  clr;
  logic  R1in;
  word_t d;
  word_t q;
`ifdef REGISTER_32_ZERO_GATE_EN
  logic  BAout;
`endif

  int checks   = 0;
  int failures = 0;

  word_t sb[$];

  typedef struct {
    logic  clr;
    logic  r1in;
    word_t d;
    word_t exp_q;
  } vec_t;

  vec_t vecs[14];

  register_32 dut (
    .clk   (clk),
    .clr   (clr),
    .R1in  (R1in),
`ifdef REGISTER_32_ZERO_GATE_EN
    .BAout (BAout),
`endif
    .d     (d),
    .q     (q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: q=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge and queue the value expected after the next rise.
  task automatic drive(input logic c, input logic en, input word_t data, input word_t exp);
    @(negedge clk);
    clr  = c;
    R1in = en;
    d    = data;
    sb.push_back(exp);
  endtask

  task automatic sample(input string name);
    word_t exp;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, q=%h", name, q);
    end else begin
      exp = sb.pop_front();
      check(name, q, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'd10,         32'd15};
    vecs[1]  = '{1'b1, 1'b0, 32'd10,         32'd15};
    vecs[2]  = '{1'b1, 1'b0, 32'd10,         32'd15};
    vecs[3]  = '{1'b1, 1'b1, 32'hDEAD_BEEF,  32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000,  32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0000,  32'h0000_0000};
    vecs[7]  = '{1'b1, 1'b1, 32'h8000_0001,  32'h8000_0001};
    vecs[8]  = '{1'b1, 1'b0, 32'h7FFF_FFFE,  32'h8000_0001};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_1234,  32'h0000_0000};
    vecs[10] = '{1'b0, 1'b1, 32'h5555_5555,  32'h0000_0000};
    vecs[11] = '{1'b1, 1'b0, 32'h7777_7777,  32'h0000_0000};
    vecs[12] = '{1'b1, 1'b1, 32'h7777_7777,  32'h7777_7777};
    vecs[13] = '{1'b1, 1'b1, 32'hA5A5_A5A5,  32'hA5A5_A5A5};

    clr  = 1'b1;
    R1in = 1'b0;
    d    = '0;
`ifdef REGISTER_32_ZERO_GATE_EN
    BAout = 1'b0;
`endif

    // Power-up clear takes effect before any rising edge.
    #1 clr = 1'b0;
    #1 check("powerup_clear", q, 32'h0);

    // Load 15: invisible before the edge, visible after it.
    drive(1'b1, 1'b1, 32'd15, 32'd15);
    #1 check("load_pre_edge", q, 32'h0);
    sample("load_post_edge");

    for (int i = 0; i < $size(vecs); i++) begin
      drive(vecs[i].clr, vecs[i].r1in, vecs[i].d, vecs[i].exp_q);
      sample($sformatf("vec%0d", i));
    end

    // Clear dominates a simultaneous load and holds across edges.
    drive(1'b1, 1'b1, 32'd15, 32'd15);
    sample("prio_setup");
    drive(1'b0, 1'b1, 32'd15, 32'd0);
    #1 check("prio_immediate", q, 32'h0);
    sample("prio_edge1");
    drive(1'b0, 1'b1, 32'd15, 32'd0);
    sample("prio_edge2");

    // Mid-cycle 2 ns clear pulse, then reload.
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    sample("mid_setup");
    #1 R1in = 1'b0;
    clr = 1'b0;
    #1 check("mid_clear_now", q, 32'h0);
    #1 clr = 1'b1;
    #1 check("mid_clear_released", q, 32'h0);
    drive(1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678);
    sample("mid_reload");

`ifdef REGISTER_32_ZERO_GATE_EN
    drive(1'b1, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    sample("ba_setup");
    @(negedge clk);
    R1in  = 1'b0;
    BAout = 1'b1;
    #1 check("ba_gate_on", q, 32'h0);
    BAout = 1'b0;
    #1 check("ba_gate_off", q, 32'hA5A5_A5A5);
    BAout = 1'b1;
    drive(1'b1, 1'b1, 32'h5A5A_5A5A, 32'h0);
    sample("ba_load_masked");
    @(negedge clk);
    R1in  = 1'b0;
    BAout = 1'b0;
    #1 check("ba_load_stored", q, 32'h5A5A_5A5A);
`endif

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_32
